// File: rtl/mem_responder_if.sv
// Bus bundle between an initiator and mem_responder.
// The initiator drives req/we/addr/wdata. The responder returns rdata/ack/busy/err.
interface mem_responder_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    logic        busy;
    logic        err;

    modport master (output req, we, addr, wdata, input rdata, ack, busy, err);
    modport slave  (input req, we, addr, wdata, output rdata, ack, busy, err);
endinterface

// File: rtl/mem_responder.sv
// Word memory responder with WAIT_CYCLES wait states and a one-cycle ack.
// Defining MEM_RESP_ERR_CHECK_EN flags misaligned or out-of-range addresses on err.
//
// state | meaning
// IDLE  | ready; accepts req and captures the access
// WAIT  | down-counting the wait states; the access fires at terminal count
// RESP  | ack (and err) held for one cycle, then back to IDLE
module mem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    mem_responder_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                  state, state_nxt;
    logic [4:0]              cnt, cnt_nxt;
    logic                    accept, fire;
    logic                    we_q;
    logic [ADDR_WIDTH-1:0]   idx_q;
    logic [31:0]             wdata_q;
    logic [31:0]             rdata_q;
    logic                    access_ok;
    logic [31:0]             mem [DEPTH];

`ifdef MEM_RESP_ERR_CHECK_EN
    logic bad_q;
    logic bad_addr;

    assign bad_addr  = (bus.addr[1:0] != 2'b00) || (bus.addr[31:ADDR_WIDTH+2] != '0);
    assign access_ok = !bad_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       bad_q <= 1'b0;
        else if (accept) bad_q <= bad_addr;
    end

    assign bus.err = (state == RESP) && bad_q;
`else
    // The address wraps modulo the array size, so these bits are never used.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.addr[31:ADDR_WIDTH+2], bus.addr[1:0]};
    assign access_ok = 1'b1;
    assign bus.err   = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 5'd0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                we_q    <= bus.we;
                idx_q   <= bus.addr[ADDR_WIDTH+1:2];
                wdata_q <= bus.wdata;
            end
            if (fire && !we_q && access_ok)
                rdata_q <= mem[idx_q];
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        fire      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req) begin
                    accept    = 1'b1;
                    cnt_nxt   = 5'(WAIT_CYCLES);
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (cnt == 5'd0) begin
                    fire      = 1'b1;
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - 5'd1;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The array has no reset. Reset forces IDLE, so a write pending in WAIT never fires.
    always_ff @(posedge clk) begin
        if (fire && we_q && access_ok)
            mem[idx_q] <= wdata_q;
    end

    assign bus.rdata = rdata_q;
    assign bus.ack   = (state == RESP);
    assign bus.busy  = (state != IDLE);
endmodule
